// File: rtl/heater_controller.sv
// Drum heater sequencer: level check, heat to the latched target, hold with
// hysteresis for a fixed time, then report done or fault to the cycle FSM.
module heater_controller #(
    parameter int HYST           = 2,
    parameter int HOLD_CYCLES    = 50,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] target_temp,
    input  logic [5:0] water_temp,
    input  logic       water_level_ok,
    output logic       heater_on,
    output logic       busy,
    output logic       heat_done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_HEAT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HEAT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [6:0]       HYST_W    = 7'(HYST);

    state_t           state_q, state_d;
    logic [5:0]       target_q, target_d;
    logic             start_prev_q;
    logic [CNT_W-1:0] heat_cnt_q, heat_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_heat_q, hold_heat_d;
    logic             heater_on_q, heater_on_d;
    logic             busy_q, busy_d;
    logic             heat_done_q, heat_done_d;
    logic             fault_q, fault_d;
    logic             start_edge;
    logic [6:0]       thr_diff;
    logic [5:0]       thr_low;

    assign start_edge = start & ~start_prev_q;

    // Bit 6 of the widened difference flags a negative threshold, which clamps to 0.
    assign thr_diff = {1'b0, target_q} - HYST_W;
    assign thr_low  = thr_diff[6] ? 6'd0 : thr_diff[5:0];

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        heat_cnt_d  = heat_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        hold_heat_d = hold_heat_q;

        if (abort) begin
            state_d     = S_IDLE;
            heat_cnt_d  = '0;
            hold_cnt_d  = '0;
            hold_heat_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start_edge) begin
                        target_d = target_temp;
                        state_d  = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!water_level_ok) begin
                        state_d = S_FAULT;
                    end else if (water_temp >= target_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_HEAT;
                        heat_cnt_d = '0;
                    end
                end
                S_HEAT: begin
                    heat_cnt_d = heat_cnt_q + CNT_W'(1);
                    if (!water_level_ok || heat_cnt_q == HEAT_LAST) begin
                        state_d = S_FAULT;
                    end else if (water_temp >= target_q) begin
                        state_d     = S_HOLD;
                        hold_cnt_d  = '0;
                        hold_heat_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    if (water_temp < thr_low) begin
                        hold_heat_d = 1'b1;
                    end else if (water_temp >= target_q) begin
                        hold_heat_d = 1'b0;
                    end
                    if (!water_level_ok) begin
                        state_d = S_FAULT;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from next state so the registered copies match the state register.
        heater_on_d = (state_d == S_HEAT) | ((state_d == S_HOLD) & hold_heat_d);
        busy_d      = (state_d == S_CHECK) | (state_d == S_HEAT) | (state_d == S_HOLD);
        fault_d     = (state_d == S_FAULT);
        heat_done_d = (state_d == S_DONE) & (state_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        // start_prev tracks start even in reset, so a start held high across reset is not an edge.
        start_prev_q <= start;
        if (reset) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            heat_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            hold_heat_q <= 1'b0;
            heater_on_q <= 1'b0;
            busy_q      <= 1'b0;
            heat_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            heat_cnt_q  <= heat_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_heat_q <= hold_heat_d;
            heater_on_q <= heater_on_d;
            busy_q      <= busy_d;
            heat_done_q <= heat_done_d;
            fault_q     <= fault_d;
        end
    end

    assign heater_on = heater_on_q;
    assign busy      = busy_q;
    assign heat_done = heat_done_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_heater_controller.sv
// Bench for heater_controller: directed scenarios plus a random run, all
// compared against a phase/elapsed-time reference model.
module tb_heater_controller;

    localparam int HYST           = 2;
    localparam int HOLD_CYCLES    = 50;
    localparam int TIMEOUT_CYCLES = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       water_level_ok = 1'b1;
    logic [5:0] target_temp = 6'd0;
    logic [5:0] water_temp = 6'd0;
    logic       heater_on, busy, heat_done, fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Model: phase number, latched target, cycles spent in the current phase.
    int m_st = 0, m_tgt = 0, m_phase_cycles = 0, m_hh = 0, m_sprev = 0, m_done = 0;

    heater_controller #(
        .HYST(HYST), .HOLD_CYCLES(HOLD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .target_temp(target_temp), .water_temp(water_temp), .water_level_ok(water_level_ok),
        .heater_on(heater_on), .busy(busy), .heat_done(heat_done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    function automatic void mdl_edge();
        int  nxt;
        int  thr;
        int  wt;
        bit  edge_seen;
        wt        = int'(water_temp);
        edge_seen = (start == 1'b1) && (m_sprev == 0);
        m_sprev   = int'(start);
        if (reset) begin
            m_st = 0; m_tgt = 0; m_phase_cycles = 0; m_hh = 0; m_done = 0;
            return;
        end
        nxt = m_st;
        if (abort) begin
            nxt  = 0;
            m_hh = 0;
        end else if (m_st == 1) begin
            if (!water_level_ok) nxt = 5;
            else if (wt >= m_tgt) nxt = 4;
            else nxt = 2;
        end else if (m_st == 2) begin
            if (!water_level_ok) nxt = 5;
            else if (m_phase_cycles >= TIMEOUT_CYCLES - 1) nxt = 5;
            else if (wt >= m_tgt) begin nxt = 3; m_hh = 0; end
        end else if (m_st == 3) begin
            thr = (m_tgt - HYST < 0) ? 0 : m_tgt - HYST;
            if (wt < thr) m_hh = 1;
            else if (wt >= m_tgt) m_hh = 0;
            if (!water_level_ok) nxt = 5;
            else if (m_phase_cycles >= HOLD_CYCLES - 1) nxt = 4;
        end else if (edge_seen) begin
            nxt   = 1;
            m_tgt = int'(target_temp);
        end
        m_done         = (nxt == 4 && m_st != 4) ? 1 : 0;
        m_phase_cycles = (nxt == m_st) ? m_phase_cycles + 1 : 0;
        m_st           = nxt;
    endfunction

    function automatic logic [6:0] mdl_vec();
        logic [2:0] s;
        s = 3'(m_st);
        return {s, (m_st == 2) || (m_st == 3 && m_hh == 1), (m_st >= 1 && m_st <= 3),
                (m_done == 1), (m_st == 5)};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {state, heater_on, busy, heat_done, fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (dut_vec() !== 7'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000", dut_vec());
        end
        reset = 1'b0;
        tick();
        total++;
        if (dut_vec() !== mdl_vec() || state !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle: got %b want %b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_heat_hold();
        target_temp = 6'd40; water_temp = 6'd20; water_level_ok = 1'b1; start = 1'b1;
        tick();
        total++;
        if (state !== 3'd1 || busy !== 1'b1 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL hh_check: state=%0d busy=%b heater=%b want 1/1/0", state, busy, heater_on);
        end
        start = 1'b0;
        tick();
        total++;
        if (state !== 3'd2 || heater_on !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hh_heat: state=%0d heater=%b busy=%b want 2/1/1", state, heater_on, busy);
        end
        repeat (5) tick();
        water_temp = 6'd40;
        tick();
        total++;
        if (state !== 3'd3 || heater_on !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hh_hold: state=%0d heater=%b busy=%b want 3/0/1", state, heater_on, busy);
        end
        for (int i = 0; i < HOLD_CYCLES - 1; i++) begin
            tick();
            total++;
            if (dut_vec() !== mdl_vec() || state !== 3'd3) begin
                bad++;
                $display("FAIL hh_hold_cyc%0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        tick();
        total++;
        if (state !== 3'd4 || heat_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hh_done: state=%0d done=%b busy=%b want 4/1/0", state, heat_done, busy);
        end
        tick();
        total++;
        if (state !== 3'd4 || heat_done !== 1'b0) begin
            bad++;
            $display("FAIL hh_done_pulse: state=%0d done=%b want 4/0", state, heat_done);
        end
    endtask

    task automatic test_cold_wash();
        target_temp = 6'd10; water_temp = 6'd15; start = 1'b1;
        tick();
        total++;
        if (state !== 3'd1 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL cold_check: state=%0d heater=%b want 1/0", state, heater_on);
        end
        start = 1'b0;
        tick();
        total++;
        if (state !== 3'd4 || heat_done !== 1'b1 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL cold_done: state=%0d done=%b heater=%b want 4/1/0", state, heat_done, heater_on);
        end
        tick();
        total++;
        if (heat_done !== 1'b0 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL cold_pulse: done=%b heater=%b want 0/0", heat_done, heater_on);
        end
    endtask

    task automatic test_hysteresis();
        target_temp = 6'd40; water_temp = 6'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        water_temp = 6'd40;
        tick();
        water_temp = 6'd38;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL hyst_38: state=%0d heater=%b want 3/0", state, heater_on);
        end
        water_temp = 6'd37;
        tick();
        total++;
        if (heater_on !== 1'b1) begin
            bad++;
            $display("FAIL hyst_37: heater=%b want 1", heater_on);
        end
        water_temp = 6'd39;
        tick();
        tick();
        total++;
        if (heater_on !== 1'b1) begin
            bad++;
            $display("FAIL hyst_39: heater=%b want 1", heater_on);
        end
        water_temp = 6'd40;
        tick();
        total++;
        if (heater_on !== 1'b0) begin
            bad++;
            $display("FAIL hyst_40: heater=%b want 0", heater_on);
        end
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            tick();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL hyst_tail_cyc%0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_timeout();
        start = 1'b0;
        tick();
        target_temp = 6'd40; water_temp = 6'd20; start = 1'b1;
        tick();
        tick();
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            tick();
            total++;
            if (dut_vec() !== mdl_vec() || state !== 3'd2) begin
                bad++;
                $display("FAIL to_heat_cyc%0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        tick();
        total++;
        if (state !== 3'd5 || fault !== 1'b1 || heater_on !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_fault: state=%0d fault=%b heater=%b busy=%b want 5/1/0/0",
                     state, fault, heater_on, busy);
        end
        start = 1'b0;
        tick();
        start = 1'b1; water_temp = 6'd45;
        tick();
        total++;
        if (state !== 3'd1 || fault !== 1'b0) begin
            bad++;
            $display("FAIL to_retry: state=%0d fault=%b want 1/0", state, fault);
        end
        tick();
        total++;
        if (state !== 3'd4 || heat_done !== 1'b1) begin
            bad++;
            $display("FAIL to_retry_done: state=%0d done=%b want 4/1", state, heat_done);
        end
        repeat (10) tick();
        total++;
        if (state !== 3'd4 || busy !== 1'b0 || heat_done !== 1'b0) begin
            bad++;
            $display("FAIL to_held_start: state=%0d busy=%b done=%b want 4/0/0", state, busy, heat_done);
        end
    endtask

    task automatic test_faults();
        start = 1'b0; water_level_ok = 1'b1;
        tick();
        target_temp = 6'd40; water_temp = 6'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        total++;
        if (state !== 3'd2 || heater_on !== 1'b1) begin
            bad++;
            $display("FAIL flt_start_in_heat: state=%0d heater=%b want 2/1", state, heater_on);
        end
        target_temp = 6'd50;
        tick();
        water_temp = 6'd40;
        tick();
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL flt_target_change: state=%0d want 3", state);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        total++;
        if (state !== 3'd0 || heat_done !== 1'b0 || busy !== 1'b0 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL flt_abort: state=%0d done=%b busy=%b heater=%b want 0/0/0/0",
                     state, heat_done, busy, heater_on);
        end
        tick();
        total++;
        if (state !== 3'd0 || heat_done !== 1'b0) begin
            bad++;
            $display("FAIL flt_abort_after: state=%0d done=%b want 0/0", state, heat_done);
        end
        target_temp = 6'd40; water_temp = 6'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        water_level_ok = 1'b0;
        tick();
        total++;
        if (state !== 3'd5 || heater_on !== 1'b0 || fault !== 1'b1) begin
            bad++;
            $display("FAIL flt_level_heat: state=%0d heater=%b fault=%b want 5/0/1", state, heater_on, fault);
        end
        start = 1'b1;
        tick();
        total++;
        if (state !== 3'd1 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL flt_level_check1: state=%0d heater=%b want 1/0", state, heater_on);
        end
        tick();
        total++;
        if (state !== 3'd5 || heater_on !== 1'b0) begin
            bad++;
            $display("FAIL flt_level_check2: state=%0d heater=%b want 5/0", state, heater_on);
        end
        start = 1'b0; water_level_ok = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_heat();
        target_temp = 6'd40; water_temp = 6'd20; start = 1'b1;
        tick();
        tick();
        total++;
        if (state !== 3'd2 || heater_on !== 1'b1) begin
            bad++;
            $display("FAIL rst_heat: state=%0d heater=%b want 2/1", state, heater_on);
        end
        reset = 1'b1;
        tick();
        total++;
        if (dut_vec() !== 7'd0) begin
            bad++;
            $display("FAIL rst_mid: got %b want 0000000", dut_vec());
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_held_start: state=%0d busy=%b want 0/0", state, busy);
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL rst_new_edge: state=%0d want 1", state);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int wt;
        int tg;
        wt = 30;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 6) start = ~start;
            abort          = ($urandom_range(199) == 0);
            water_level_ok = ($urandom_range(99) != 0);
            reset          = ($urandom_range(499) == 0);
            if ($urandom_range(99) < 4) begin
                tg = int'($urandom_range(55));
                target_temp = 6'(tg);
            end
            if (m_st == 2) wt = wt + int'($urandom_range(2));
            else wt = wt + int'($urandom_range(4)) - 2;
            if (wt < 0) wt = 0;
            if (wt > 63) wt = 63;
            water_temp = 6'(wt);
            tick();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL rand_cyc%0d: got {st,heat,busy,done,flt}=%b want %b", i, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_heat_hold();
        test_cold_wash();
        test_hysteresis();
        test_timeout();
        test_faults();
        test_reset_mid_heat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
